// File: rtl/orangecrab_reset_ctrl.sv
// Reboot sequencer: arbitrates reboot requesters, qualifies the winner, runs a
// cancellable warn-blink hold-off, then latches do_reset until rst.
module orangecrab_reset_ctrl #(
    parameter int N_REQ          = 3,
    parameter int QUAL_CYCLES    = 4800000,
    parameter int HOLDOFF_CYCLES = 48000000,
    parameter int WARN_PERIOD    = 2400000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_mask,
    input  logic             cancel,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             warn,
    output logic             do_reset
);

    // state   | meaning
    // IDLE    | waiting for an eligible request
    // QUALIFY | granted request must stay high for QUAL_CYCLES samples
    // HOLDOFF | cancellable countdown, warn blinking
    // FIRE    | do_reset latched until rst
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] QUALIFY = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;
    localparam logic [1:0] FIRE    = 2'd3;

    localparam int MAX_QH  = (QUAL_CYCLES > HOLDOFF_CYCLES) ? QUAL_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_ALL = (MAX_QH > WARN_PERIOD) ? MAX_QH : WARN_PERIOD;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] WARN_LAST = CW'(WARN_PERIOD - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    warn_cnt;
    logic [N_REQ-1:0] blocked;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick;

    assign eligible = req & req_mask & ~blocked;
    // isolate the lowest set bit: index 0 has highest priority
    assign pick     = eligible & (~eligible + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            warn     <= 1'b0;
            do_reset <= 1'b0;
            cnt      <= '0;
            warn_cnt <= '0;
            blocked  <= '0;
        end else begin
            // a blocked source is released once its request is seen low
            blocked <= blocked & req;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state <= QUALIFY;
                        grant <= pick;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                QUALIFY: begin
                    if (cancel) begin
                        state   <= IDLE;
                        blocked <= (blocked & req) | grant;
                        grant   <= '0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                    end else if (!(|(req & grant))) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == QUAL_LAST) begin
                        state    <= HOLDOFF;
                        cnt      <= '0;
                        warn_cnt <= '0;
                        warn     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cancel) begin
                        state    <= IDLE;
                        blocked  <= (blocked & req) | grant;
                        grant    <= '0;
                        busy     <= 1'b0;
                        warn     <= 1'b0;
                        cnt      <= '0;
                        warn_cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state    <= FIRE;
                        do_reset <= 1'b1;
                        warn     <= 1'b0;
                        cnt      <= '0;
                        warn_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (warn_cnt == WARN_LAST) begin
                            warn     <= ~warn;
                            warn_cnt <= '0;
                        end else begin
                            warn_cnt <= warn_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    do_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_orangecrab_reset_ctrl.sv
// Directed bench for orangecrab_reset_ctrl with short qualify/hold-off timings.
module tb_orangecrab_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = '0;
    logic [2:0] req_mask = 3'b111;
    logic       cancel = 1'b0;
    logic [2:0] grant;
    logic       busy;
    logic       warn;
    logic       do_reset;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [9:0] warn_exp;

    orangecrab_reset_ctrl #(
        .N_REQ(3), .QUAL_CYCLES(4), .HOLDOFF_CYCLES(10), .WARN_PERIOD(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_mask(req_mask), .cancel(cancel),
        .grant(grant), .busy(busy), .warn(warn), .do_reset(do_reset)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        req = '0;
        cancel = 1'b0;
        req_mask = 3'b111;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // reset state
        do_rst();
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_warn", 32'(warn), 0);
        check("rst_do_reset", 32'(do_reset), 0);

        // 1: held request fires at 15; 6: rst in FIRE clears
        req = 3'b001;
        run_to(1);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 1);
        run_to(4);
        check("t1_warn_qual", 32'(warn), 0);
        run_to(5);
        check("t1_warn_entry", 32'(warn), 1);
        run_to(14);
        check("t1_no_fire_14", 32'(do_reset), 0);
        run_to(15);
        check("t1_fire_15", 32'(do_reset), 1);
        check("t1_warn_fire", 32'(warn), 0);
        req = 3'b000;
        cancel = 1'b1;
        run_to(20);
        check("t1_sticky", 32'(do_reset), 1);
        check("t1_busy_fire", 32'(busy), 1);
        cancel = 1'b0;
        rst = 1'b1;
        step();
        check("t6_rst_do_reset", 32'(do_reset), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_grant", 32'(grant), 0);

        // 2: drop during qualify, re-raise later
        do_rst();
        req = 3'b001;
        run_to(2);
        req = 3'b000;
        run_to(3);
        check("t2_idle_busy", 32'(busy), 0);
        check("t2_idle_grant", 32'(grant), 0);
        run_to(6);
        req = 3'b001;
        run_to(7);
        check("t2_regrant", 32'(grant), 32'h1);
        run_to(20);
        check("t2_no_fire_20", 32'(do_reset), 0);
        run_to(21);
        check("t2_fire_21", 32'(do_reset), 1);

        // 3: priority pick and no preemption
        do_rst();
        req = 3'b110;
        run_to(1);
        check("t3_grant", 32'(grant), 32'h2);
        run_to(7);
        req = 3'b111;
        run_to(8);
        check("t3_no_preempt", 32'(grant), 32'h2);
        run_to(14);
        check("t3_no_fire_14", 32'(do_reset), 0);
        run_to(15);
        check("t3_fire_15", 32'(do_reset), 1);
        check("t3_grant_fire", 32'(grant), 32'h2);

        // 4: cancel in hold-off blocks the source until it drops
        do_rst();
        req = 3'b010;
        run_to(8);
        cancel = 1'b1;
        run_to(9);
        cancel = 1'b0;
        check("t4_cancel_busy", 32'(busy), 0);
        check("t4_cancel_grant", 32'(grant), 0);
        check("t4_cancel_warn", 32'(warn), 0);
        run_to(14);
        check("t4_blocked", 32'(busy), 0);
        req = 3'b000;
        run_to(15);
        check("t4_low_busy", 32'(busy), 0);
        req = 3'b010;
        run_to(16);
        check("t4_reentry_busy", 32'(busy), 1);
        check("t4_reentry_grant", 32'(grant), 32'h2);

        // 5: warn pattern and cancel on final hold-off cycle
        do_rst();
        warn_exp = 10'b1100110011;
        req = 3'b001;
        run_to(5);
        for (int i = 0; i < 10; i++) begin
            run_to(5 + i);
            check($sformatf("t5_warn_%0d", 5 + i), 32'(warn), 32'(warn_exp[9 - i]));
        end
        cancel = 1'b1;
        run_to(15);
        cancel = 1'b0;
        check("t5_cancel_busy", 32'(busy), 0);
        check("t5_cancel_do_reset", 32'(do_reset), 0);
        check("t5_cancel_warn", 32'(warn), 0);
        run_to(20);
        check("t5_still_idle", 32'(do_reset | busy), 0);

        // 6b: masked sources never start; mask change in flight is ignored
        do_rst();
        req_mask = 3'b000;
        req = 3'b111;
        for (int i = 1; i <= 50; i++) begin
            run_to(i);
            check("t6_mask_busy", 32'(busy), 0);
        end
        req_mask = 3'b100;
        run_to(51);
        check("t6_mask_grant", 32'(grant), 32'h4);
        req_mask = 3'b000;
        run_to(65);
        check("t6_mask_fire", 32'(do_reset), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
